alu_sequential_n_bit: RTL and testbench

Parametrised, clocked successor to the combinational 16-bit ALU, with the same 16-operation opcode map. Operands are captured on a start handshake. Logical, add and subtract operations complete in one cycle. Multiply, divide and modulo run as iterative multi-cycle engines. Results are registered, with carry, zero, negative, overflow and divide-by-zero flags. The block sits between the datapath register file and writeback and may replace the combinational ALU wherever a registered result is acceptable.

---
 rtl/alu_sequential_n_bit_if.sv | 33 +++
 rtl/alu_sequential_n_bit.sv | 210 +++++++++++++++++++++
 tb/tb_alu_sequential_n_bit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequential_n_bit_if.sv
// alu_sequential_n_bit_if -- request/response bundle of the sequential ALU.
// The requester drives operands, opcode, Start and Enable; the ALU returns
// the registered result, status flags and the Busy/Valid handshake.
interface alu_sequential_n_bit_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  Enable_In;
  logic                  Start_In;
  logic [3:0]            ALU_Operation_Select_In;
  logic [DATA_WIDTH-1:0] Data_A_In;
  logic [DATA_WIDTH-1:0] Data_B_In;
  logic                  Busy_Out;
  logic                  Valid_Out;
  logic [DATA_WIDTH-1:0] Result_Out;
  logic                  Carry_Out;
  logic                  Zero_Out;
  logic                  Negative_Out;
  logic                  Overflow_Out;
  logic                  Div_Zero_Out;
  logic                  Illegal_Op_Out;

  modport master (
    output Enable_In, Start_In, ALU_Operation_Select_In, Data_A_In, Data_B_In,
    input  Busy_Out, Valid_Out, Result_Out, Carry_Out, Zero_Out, Negative_Out,
           Overflow_Out, Div_Zero_Out, Illegal_Op_Out
  );

  modport slave (
    input  Enable_In, Start_In, ALU_Operation_Select_In, Data_A_In, Data_B_In,
    output Busy_Out, Valid_Out, Result_Out, Carry_Out, Zero_Out, Negative_Out,
           Overflow_Out, Div_Zero_Out, Illegal_Op_Out
  );
endinterface

// File: rtl/alu_sequential_n_bit.sv
// alu_sequential_n_bit -- registered N-bit ALU with the 16-op opcode map.
// Build option: define ALU_MUL_DIV_EN to include the iterative shift-add
// multiplier / restoring divider (ops 5-7, N+1 cycle latency). Without it,
// ops 5-7 finish in one cycle with a zero result and Illegal_Op_Out set.
module alu_sequential_n_bit #(
  parameter int DATA_WIDTH = 16
) (
  input logic                   Clk_In,
  input logic                   Reset_n_In,
  alu_sequential_n_bit_if.slave bus
);
  localparam int N = DATA_WIDTH;
  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, ITER = 2'd2} state_t;

  state_t       state, state_nx;
  logic         en;
  logic [3:0]   op;
  logic [N-1:0] opa, opb;
  logic [N:0]   a_x, b_x;
  logic         go_iter, last_iter, finish;
  logic [N:0]   res_nx;
  logic         ov_nx, dz_nx, ill_nx;
  logic         valid_q, carry_q, zero_q, neg_q, ov_q, dz_q, ill_q;
  logic [N-1:0] result_q;

  assign en  = bus.Enable_In;
  assign a_x = {1'b0, opa};
  assign b_x = {1'b0, opb};

`ifdef ALU_MUL_DIV_EN
  localparam int CW = $clog2(N + 1);

  // work_hi: product high half / partial remainder
  // work_lo: multiplier being consumed / dividend shifting out, quotient in
  logic [CW-1:0] cnt;
  logic [N-1:0]  work_hi, work_lo, hi_nx, lo_nx;
  logic [N:0]    mul_sum, rem_sh;
  logic          ge, b_zero, is_muldiv;

  assign b_zero    = (opb == '0);
  assign is_muldiv = (op == 4'h5) || (op == 4'h6) || (op == 4'h7);
  // divide by zero short-circuits in EXEC; multiply by zero still iterates
  assign go_iter   = is_muldiv && !(b_zero && (op != 4'h5));
  assign last_iter = (state == ITER) && (cnt == CW'(1));
`else
  assign go_iter   = 1'b0;
  assign last_iter = 1'b0;
`endif

  assign finish = ((state == EXEC) && !go_iter) || last_iter;

  // State register; Enable_In low freezes the FSM.
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In)  state <= IDLE;
    else if (en)      state <= state_nx;
  end

  // Next state: every op passes through EXEC, mul/div then spends N cycles in ITER.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.Start_In) state_nx = EXEC;
      EXEC:    state_nx = go_iter ? ITER : IDLE;
`ifdef ALU_MUL_DIV_EN
      ITER:    if (last_iter) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Output/result decode: {carry,result} as the (N+1)-bit truncation per opcode.
  always_comb begin
    res_nx = '0;
    ov_nx  = 1'b0;
    dz_nx  = 1'b0;
    ill_nx = 1'b0;
    case (op)
      4'h0: begin
        res_nx = a_x + ONE;
        ov_nx  = !opa[N-1] && res_nx[N-1];
      end
      4'h1: begin
        res_nx = a_x - ONE;
        ov_nx  = opa[N-1] && !res_nx[N-1];
      end
      4'h2: begin
        res_nx = a_x + b_x;
        ov_nx  = (opa[N-1] == opb[N-1]) && (res_nx[N-1] != opa[N-1]);
      end
      4'h3: begin
        res_nx = a_x - b_x;
        ov_nx  = (opa[N-1] != opb[N-1]) && (res_nx[N-1] != opa[N-1]);
      end
      4'h4: begin
        res_nx = b_x - a_x;
        ov_nx  = (opb[N-1] != opa[N-1]) && (res_nx[N-1] != opb[N-1]);
      end
      4'h5, 4'h6, 4'h7: begin
`ifdef ALU_MUL_DIV_EN
        // final ITER step feeds the result straight from the step logic
        if (b_zero && (op != 4'h5)) begin
          dz_nx  = 1'b1;
          res_nx = (op == 4'h6) ? {1'b0, {N{1'b1}}} : a_x;
        end else if (op == 4'h5) begin
          res_nx = {hi_nx[0], lo_nx};
        end else if (op == 4'h6) begin
          res_nx = {1'b0, lo_nx};
        end else begin
          res_nx = {1'b0, hi_nx};
        end
`else
        ill_nx = 1'b1;
`endif
      end
      4'h8:    res_nx = {1'b0, opa & opb};
      4'h9:    res_nx = {1'b0, opa | opb};
      4'hA:    res_nx = {1'b0, ~opa};
      4'hB:    res_nx = {1'b0, ~opb};
      4'hC:    res_nx = {1'b0, ~(opa & opb)};
      4'hD:    res_nx = {1'b0, ~(opa | opb)};
      4'hE:    res_nx = {1'b0, opa ^ opb};
      default: res_nx = {1'b0, ~(opa ^ opb)};
    endcase
  end

  // Operand capture on accept; result and flags load only on the finishing edge.
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      op       <= '0;
      opa      <= '0;
      opb      <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      ov_q     <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else if (en) begin
      if ((state == IDLE) && bus.Start_In) begin
        op  <= bus.ALU_Operation_Select_In;
        opa <= bus.Data_A_In;
        opb <= bus.Data_B_In;
      end
      valid_q <= finish;
      if (finish) begin
        result_q <= res_nx[N-1:0];
        carry_q  <= res_nx[N];
        zero_q   <= (res_nx[N-1:0] == '0);
        neg_q    <= res_nx[N-1];
        ov_q     <= ov_nx;
        dz_q     <= dz_nx;
        ill_q    <= ill_nx;
      end
    end
  end

`ifdef ALU_MUL_DIV_EN
  // One engine step: shift-add multiply bit, or one restoring-division bit.
  always_comb begin
    mul_sum = '0;
    rem_sh  = '0;
    ge      = 1'b0;
    hi_nx   = work_hi;
    lo_nx   = work_lo;
    if (op == 4'h5) begin
      mul_sum = {1'b0, work_hi} + (work_lo[0] ? a_x : '0);
      hi_nx   = mul_sum[N:1];
      lo_nx   = {mul_sum[0], work_lo[N-1:1]};
    end else begin
      rem_sh = {work_hi, work_lo[N-1]};
      ge     = (rem_sh >= b_x);
      hi_nx  = ge ? N'(rem_sh - b_x) : rem_sh[N-1:0];
      lo_nx  = {work_lo[N-2:0], ge};
    end
  end

  // Engine registers: seeded in EXEC, stepped and counted down in ITER.
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      cnt     <= '0;
      work_hi <= '0;
      work_lo <= '0;
    end else if (en) begin
      if (state == EXEC) begin
        cnt     <= CW'(N);
        work_hi <= '0;
        work_lo <= (op == 4'h5) ? opb : opa;
      end else if (state == ITER) begin
        cnt     <= cnt - CW'(1);
        work_hi <= hi_nx;
        work_lo <= lo_nx;
      end
    end
  end
`endif

  assign bus.Busy_Out       = (state != IDLE);
  assign bus.Valid_Out      = valid_q;
  assign bus.Result_Out     = result_q;
  assign bus.Carry_Out      = carry_q;
  assign bus.Zero_Out       = zero_q;
  assign bus.Negative_Out   = neg_q;
  assign bus.Overflow_Out   = ov_q;
  assign bus.Div_Zero_Out   = dz_q;
  assign bus.Illegal_Op_Out = ill_q;
endmodule

// File: tb/tb_alu_sequential_n_bit.sv
// tb_alu_sequential_n_bit -- scoreboard bench for alu_sequential_n_bit, N=16.
// The driver pushes the expected result (value, flags, arrival cycle) on each
// accept; the monitor pops and compares on every rising Valid_Out.
// Follows ALU_MUL_DIV_EN the same way as the design build.
module tb_alu_sequential_n_bit;
  localparam int N = 16;
`ifdef ALU_MUL_DIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] res;
    logic         c, z, n, ov, dz, ill;
    int           cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic prev_valid = 1'b0;
  exp_t q[$];

  alu_sequential_n_bit_if #(.DATA_WIDTH(N)) bus ();
  alu_sequential_n_bit #(.DATA_WIDTH(N)) dut (
    .Clk_In    (clk),
    .Reset_n_In(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode rules.
  function automatic exp_t model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t   e;
    longint ua, ub, r, mask;
    int     sa, sb, sr;
    bit     sgn;
    mask = (64'd1 << N) - 1;
    ua = longint'(a);
    ub = longint'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0; sr = 0; sgn = 1'b0;
    e = '{res: '0, c: 1'b0, z: 1'b0, n: 1'b0, ov: 1'b0, dz: 1'b0, ill: 1'b0, cyc: 0};
    case (op)
      4'h0: begin r = ua + 1;  sr = sa + 1;  sgn = 1'b1; end
      4'h1: begin r = ua - 1;  sr = sa - 1;  sgn = 1'b1; end
      4'h2: begin r = ua + ub; sr = sa + sb; sgn = 1'b1; end
      4'h3: begin r = ua - ub; sr = sa - sb; sgn = 1'b1; end
      4'h4: begin r = ub - ua; sr = sb - sa; sgn = 1'b1; end
      4'h5: r = ua * ub;
      4'h6: r = (ub == 0) ? mask : ua / ub;
      4'h7: r = (ub == 0) ? ua : ua % ub;
      4'h8: r = ua & ub;
      4'h9: r = ua | ub;
      4'hA: r = ~ua & mask;
      4'hB: r = ~ub & mask;
      4'hC: r = ~(ua & ub) & mask;
      4'hD: r = ~(ua | ub) & mask;
      4'hE: r = ua ^ ub;
      default: r = ~(ua ^ ub) & mask;
    endcase
    if (op >= 4'h5 && op <= 4'h7 && !MULDIV) begin
      r = 0;
      e.ill = 1'b1;
    end else if ((op == 4'h6 || op == 4'h7) && ub == 0) begin
      e.dz = 1'b1;
    end
    e.res = r[N-1:0];
    e.c   = r[N];
    e.z   = (e.res == '0);
    e.n   = e.res[N-1];
    e.ov  = sgn && (sr > 32767 || sr < -32768);
    return e;
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [N-1:0] b);
    if (MULDIV && (op == 4'h5 || ((op == 4'h6 || op == 4'h7) && b != '0))) return N + 1;
    return 1;
  endfunction

  // Monitor: one comparison set per result (a stalled, held Valid_Out is one result).
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.Valid_Out && !prev_valid) begin
        chk("result_was_expected", (q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("result", bus.Result_Out, e.res);
          chk("carry", bus.Carry_Out, e.c);
          chk("zero", bus.Zero_Out, e.z);
          chk("negative", bus.Negative_Out, e.n);
          chk("overflow", bus.Overflow_Out, e.ov);
          chk("div_zero", bus.Div_Zero_Out, e.dz);
          chk("illegal_op", bus.Illegal_Op_Out, e.ill);
          chk("busy_at_valid", bus.Busy_Out, 0);
        end
      end
      prev_valid = bus.Valid_Out;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, bus.Busy_Out, 0);
    chk({tag, "_valid"}, bus.Valid_Out, 0);
    chk({tag, "_result"}, bus.Result_Out, 0);
    chk({tag, "_carry"}, bus.Carry_Out, 0);
    chk({tag, "_zero"}, bus.Zero_Out, 1);
    chk({tag, "_negative"}, bus.Negative_Out, 0);
    chk({tag, "_overflow"}, bus.Overflow_Out, 0);
    chk({tag, "_div_zero"}, bus.Div_Zero_Out, 0);
    chk({tag, "_illegal"}, bus.Illegal_Op_Out, 0);
  endtask

  // Issue one op; optional Enable stall of sl cycles starting sa cycles after
  // accept; optional Start poke while busy (must be ignored).
  task automatic run_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int sa, input int sl, input bit poke);
    exp_t e;
    int   t, lat;
    bit   done;
    @(negedge clk);
    chk("idle_before_start", bus.Busy_Out, 0);
    bus.ALU_Operation_Select_In = op;
    bus.Data_A_In = a;
    bus.Data_B_In = b;
    bus.Start_In  = 1'b1;
    e   = model(op, a, b);
    lat = latency(op, b);
    @(posedge clk);
    #1;
    t = cyc;
    e.cyc = t + lat + ((sl > 0 && sa < lat) ? sl : 0);
    q.push_back(e);
    chk("busy_after_accept", bus.Busy_Out, 1);
    @(negedge clk);
    bus.Start_In  = 1'b0;
    bus.Data_A_In = N'($urandom);
    bus.Data_B_In = N'($urandom);
    bus.ALU_Operation_Select_In = 4'($urandom);
    if (sl > 0) begin
      repeat (sa) @(negedge clk);
      bus.Enable_In = 1'b0;
      repeat (sl) @(negedge clk);
      bus.Enable_In = 1'b1;
    end
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!bus.Busy_Out) begin
        done = 1'b1;
        break;
      end
      if (poke) bus.Start_In = (k == 3);
      @(negedge clk);
    end
    bus.Start_In = 1'b0;
    chk("op_completes", done, 1);
    if (done && !(sl > 0 && sa >= lat)) chk("busy_fall_cycle", cyc, e.cyc);
  endtask

  // Start a multiply, pull reset `after` cycles in, and watch for a stray result.
  task automatic reset_mid(input int after);
    exp_t e;
    int   t, lat;
    @(negedge clk);
    bus.ALU_Operation_Select_In = 4'h5;
    bus.Data_A_In = 16'h8001;
    bus.Data_B_In = 16'h0003;
    bus.Start_In  = 1'b1;
    e   = model(4'h5, 16'h8001, 16'h0003);
    lat = latency(4'h5, 16'h0003);
    @(posedge clk);
    #1;
    t = cyc;
    if (lat <= after) begin
      e.cyc = t + lat;
      q.push_back(e);
    end
    @(negedge clk);
    bus.Start_In = 1'b0;
    repeat (after - 1) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 8) @(negedge clk);
    chk("busy_after_abort", bus.Busy_Out, 0);
    chk("valid_after_abort", bus.Valid_Out, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0]   op;
    logic [N-1:0] a, b;
    int           sa, sl;
    bit           poke;
    bus.Enable_In = 1'b1;
    bus.Start_In  = 1'b0;
    bus.ALU_Operation_Select_In = 4'h0;
    bus.Data_A_In = '0;
    bus.Data_B_In = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    run_op(4'h2, 16'hFFFF, 16'h0001, 0, 0, 1'b0);
    run_op(4'h3, 16'h0003, 16'h0005, 0, 0, 1'b0);
    run_op(4'h2, 16'h7FFF, 16'h0001, 0, 0, 1'b0);
    run_op(4'h5, 16'h8001, 16'h0003, 0, 0, 1'b1);
    run_op(4'h6, 16'h03E8, 16'h0007, 0, 0, 1'b0);
    run_op(4'h7, 16'h03E8, 16'h0007, 0, 0, 1'b0);
    run_op(4'h6, 16'h1234, 16'h0000, 0, 0, 1'b0);
    run_op(4'h7, 16'h1234, 16'h0000, 0, 0, 1'b0);
    run_op(4'h5, 16'h0002, 16'h0003, 0, 0, 1'b0);
    run_op(4'h8, 16'hA5A5, 16'h0FF0, 0, 0, 1'b0);
    run_op(4'h5, 16'h8001, 16'h0003, 5, 3, 1'b0);
    run_op(4'h2, 16'h1234, 16'h1111, 0, 3, 1'b0);
    run_op(4'h9, 16'h00F0, 16'h0F00, 1, 3, 1'b0);
    run_op(4'h1, 16'h0000, 16'h0000, 0, 0, 1'b0);
    run_op(4'h1, 16'h8000, 16'h0000, 0, 0, 1'b0);
    run_op(4'h0, 16'h7FFF, 16'h0000, 0, 0, 1'b0);
    run_op(4'h4, 16'h8000, 16'h0001, 0, 0, 1'b0);
    run_op(4'hF, 16'h1234, 16'h1234, 0, 0, 1'b0);

    for (int i = 0; i < 70; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       a = 16'h7FFF;
        1:       a = 16'h8000;
        2:       a = 16'hFFFF;
        default: a = N'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 16'hFFFF;
        2:       b = N'($urandom_range(1, 15));
        default: b = N'($urandom);
      endcase
      sa = 0;
      sl = 0;
      if ($urandom_range(0, 4) == 0) begin
        sl = $urandom_range(1, 3);
        sa = $urandom_range(0, 20);
      end
      poke = ($urandom_range(0, 3) == 0);
      run_op(op, a, b, sa, sl, poke);
    end

    reset_mid(5);
    run_op(4'hE, 16'h5A5A, 16'hFFFF, 0, 0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
